// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: instruction kinds, opcode/funct constants,
// field-packing helpers and the encoder state enum.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BEQ  = 4'd7,
    K_ADDI = 4'd8,
    K_J    = 4'd9
  } instr_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FULL,
    S_DONE
  } enc_state_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [25:0] target);
    return {OP_J, target};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic instruction kind plus fields to a 32-bit
// MIPS word, with a legal flag for kinds outside the supported set.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (instr_kind_t'(kind))
      K_ADD:   word = r_word(rs, rt, rd, FN_ADD);
      K_SUB:   word = r_word(rs, rt, rd, FN_SUB);
      K_AND:   word = r_word(rs, rt, rd, FN_AND);
      K_OR:    word = r_word(rs, rt, rd, FN_OR);
      K_SLT:   word = r_word(rs, rt, rd, FN_SLT);
      K_LW:    word = i_word(OP_LW, rs, rt, imm);
      K_SW:    word = i_word(OP_SW, rs, rt, imm);
      K_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      K_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      K_J:     word = j_word(target);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic instructions over valid/ready, packs them
// and writes them to consecutive instruction-memory words starting at 0.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic              done
);

  localparam logic [ADDR_W:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  enc_state_t      state_q, state_d;
  logic [ADDR_W:0] word_count_q, word_count_d;
  logic [31:0]     word_q, word_d;
  logic            err_q, err_d;
  logic            finish_pend_q, finish_pend_d;
  logic [31:0]     packed_word;
  logic            packed_legal;
  logic [ADDR_W:0] count_inc;

  instr_pack u_pack (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign count_inc = word_count_q + COUNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count_q  <= '0;
      word_q        <= '0;
      err_q         <= 1'b0;
      finish_pend_q <= 1'b0;
    end else begin
      word_count_q  <= word_count_d;
      word_q        <= word_d;
      err_q         <= err_d;
      finish_pend_q <= finish_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_count_d  = word_count_q;
    word_d        = word_q;
    err_d         = err_q;
    finish_pend_d = finish_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          word_count_d  = '0;
          err_d         = 1'b0;
          finish_pend_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (packed_legal) begin
            // A finish arriving with a legal word is deferred until that word is written.
            word_d        = packed_word;
            finish_pend_d = finish;
            state_d       = S_WRITE;
          end else begin
            err_d = 1'b1;
            if (finish) state_d = S_DONE;
          end
        end else if (finish) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        word_count_d = count_inc;
        if (finish_pend_q) begin
          state_d       = S_DONE;
          finish_pend_d = 1'b0;
        end else if (count_inc == CAPACITY) begin
          state_d = S_FULL;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FULL: begin
        if (finish) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    busy       = (state_q != S_IDLE);
    full       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_LOAD:  in_ready = 1'b1;
      S_WRITE: begin
        imem_we    = 1'b1;
        imem_addr  = word_count_q[ADDR_W-1:0];
        imem_wdata = word_q;
      end
      S_FULL:  full = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign word_count = word_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder with a 4-word memory: directed
// program-load scenarios plus randomized sessions against an arithmetic model.
module tb_instr_encoder;

  localparam int unsigned AW  = 2;
  localparam int unsigned CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_kind = '0;
  logic [4:0]    in_rs = '0;
  logic [4:0]    in_rt = '0;
  logic [4:0]    in_rd = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          busy;
  logic          full;
  logic          err;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  int exp_err = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .busy       (busy),
    .full       (full),
    .err        (err),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_encode(input int k, input longint unsigned rs,
                                             input longint unsigned rt, input longint unsigned rd,
                                             input longint unsigned imm, input longint unsigned tgt);
    longint unsigned op;
    longint unsigned fn;
    longint unsigned w;
    op = 0;
    fn = 0;
    case (k)
      0: fn = 32;
      1: fn = 34;
      2: fn = 36;
      3: fn = 37;
      4: fn = 42;
      5: op = 35;
      6: op = 43;
      7: op = 4;
      8: op = 8;
      default: op = 2;
    endcase
    if (k <= 4)      w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + fn;
    else if (k <= 8) w = op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    else             w = op * (1 << 26) + tgt;
    return w[31:0];
  endfunction

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_cnt = 0;
    exp_err = 0;
    check("start_busy", busy, 1);
    check("start_count", word_count, 0);
    check("start_err", err, 0);
    check("start_ready", in_ready, 1);
  endtask

  task automatic send(input int k, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input bit fin, output logic [31:0] obs);
    @(negedge clk);
    check("ready_before", in_ready, 1);
    in_valid = 1'b1;
    in_kind = 4'(k);
    in_rs = 5'(rs);
    in_rt = 5'(rt);
    in_rd = 5'(rd);
    in_imm = 16'(imm);
    in_target = 26'(tgt);
    finish = fin;
    @(negedge clk);
    in_valid = 1'b0;
    finish = 1'b0;
    check("we", imem_we, 1);
    check("addr", imem_addr, exp_cnt);
    check("wdata", imem_wdata, ref_encode(k, rs, rt, rd, imm, tgt));
    check("no_ready_in_write", in_ready, 0);
    obs = imem_wdata;
    exp_cnt++;
    @(negedge clk);
    check("we_drop", imem_we, 0);
    check("count", word_count, exp_cnt);
    if (fin) begin
      check("fin_done", done, 1);
      @(negedge clk);
      check("fin_done_drop", done, 0);
      check("fin_idle", busy, 0);
    end else begin
      check("full_flag", full, exp_cnt == CAP);
      check("ready_after", in_ready, exp_cnt != CAP);
    end
  endtask

  task automatic send_illegal(input int k, input bit fin);
    @(negedge clk);
    in_valid = 1'b1;
    in_kind = 4'(k);
    finish = fin;
    @(negedge clk);
    in_valid = 1'b0;
    finish = 1'b0;
    exp_err = 1;
    check("illegal_no_we", imem_we, 0);
    check("illegal_err", err, 1);
    check("illegal_count", word_count, exp_cnt);
    if (fin) begin
      check("illegal_fin_done", done, 1);
      @(negedge clk);
      check("illegal_fin_idle", busy, 0);
    end else begin
      check("illegal_ready", in_ready, 1);
    end
  endtask

  task automatic end_session();
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("end_done", done, 1);
    check("end_no_we", imem_we, 0);
    @(negedge clk);
    check("end_done_drop", done, 0);
    check("end_idle", busy, 0);
    check("end_count_hold", word_count, exp_cnt);
    check("end_err_hold", err, exp_err);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    int k;
    bit fin;

    #1;
    check("rst_ctrl", {in_ready, imem_we, busy, full, err, done}, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", word_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_not_ready", in_ready, 0);

    // Session A: directed words, ignored start, illegal kind, fill to capacity.
    start_session();
    send(0, 1, 2, 3, 0, 0, 0, w);
    check("add_word", w, 32'h0022_1820);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_count", word_count, 1);
    check("start_ignored_busy", busy, 1);
    send(5, 29, 8, 0, 4, 0, 0, w);
    check("lw_word", w, 32'h8FA8_0004);
    send_illegal(15, 0);
    send(6, 29, 8, 0, 8, 0, 0, w);
    check("sw_word", w, 32'hAFA8_0008);
    send(7, 4, 5, 0, 16'hFFFF, 0, 0, w);
    check("beq_word", w, 32'h1085_FFFF);
    check("full_set", full, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_kind = 4'd9;
    in_target = 26'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_no_we", imem_we, 0);
      check("full_no_ready", in_ready, 0);
      check("full_count", word_count, CAP);
    end
    in_valid = 1'b0;
    end_session();

    // Session B: jump, then finish together with a legal ADDI.
    start_session();
    send(9, 0, 0, 0, 0, 26'h10, 0, w);
    check("j_word", w, 32'h0800_0010);
    send(8, 0, 9, 0, 7, 0, 1, w);
    check("addi_word", w, 32'h2009_0007);
    check("addi_count_hold", word_count, 2);

    // Session C: finish together with an illegal handshake.
    start_session();
    send_illegal(12, 1);
    check("c_err_hold", err, 1);

    // Randomized sessions against the model.
    for (int s = 0; s < 8; s++) begin
      start_session();
      n = $urandom_range(1, CAP);
      fin = 1'b0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) send_illegal(10 + $urandom_range(0, 5), 0);
        k = $urandom_range(0, 9);
        fin = (i == n - 1) && ($urandom_range(0, 1) == 1);
        send(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1), fin, w);
      end
      if (!fin) end_session();
    end

    // Asynchronous reset while a word is being written.
    start_session();
    @(negedge clk);
    in_valid = 1'b1;
    in_kind = 4'd1;
    in_rs = 5'd7;
    in_rt = 5'd6;
    in_rd = 5'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_we", imem_we, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", {in_ready, imem_we, busy, full, err, done}, 0);
    check("async_rst_addr", imem_addr, 0);
    check("async_rst_wdata", imem_wdata, 0);
    check("async_rst_count", word_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and program loader for the single-cycle CPU's instruction memory.
- Accepts symbolic instruction requests (kind plus register, immediate and target fields) over a valid/ready handshake.
- Packs each request into the 32-bit word that the CPU's main decoder and ALU decoder consume.
- Writes words to consecutive instruction-memory addresses from 0 upward.
- Sits between the testbench/boot host and the imem write port, so programs are built from fields rather than hand-written hex.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2**ADDR_W words.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  in IDLE, clears pointer and error, enters LOAD.
- finish  in  1  ends the load session.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_kind  in  4  instr_kind_t: ADD, SUB, AND, OR, SLT, LW, SW, BEQ, ADDI, J.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written this session.
- busy  out  1  state is not IDLE.
- full  out  1  memory capacity reached.
- err  out  1  sticky: an illegal kind was received.
- done  out  1  one-cycle pulse on session end.

## Operation
- Reset state:
  - State is IDLE.
  - Outputs in_ready, imem_we, busy, full, err and done are 0.
  - imem_addr, imem_wdata and word_count are 0.
- States and transitions:
  - IDLE: start -> LOAD. In the same edge, word_count←0 and err←0.
  - LOAD: in_ready=1.
    - Handshake (in_valid and in_ready) with a legal kind: register the encoded word, -> WRITE.
    - Handshake with an illegal kind: err←1, nothing is written, stay in LOAD.
    - finish with no handshake: -> DONE.
  - WRITE: imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=held word. At the edge, word_count increments.
    - Next state is DONE if finish_pend is set.
    - Otherwise FULL if the new word_count equals 2**ADDR_W.
    - Otherwise LOAD.
  - FULL: in_ready=0, full=1. finish -> DONE. Any in_valid is left pending and never accepted.
  - DONE: done=1 for exactly one cycle, then IDLE. word_count and err hold their values until the next start.
- Encoding (field layout op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]):
  - R-type (ADD, SUB, AND, OR, SLT): op=000000, shamt=0, funct from the package.
  - I-type (LW, SW, BEQ, ADDI): op from the package, rs, rt, imm in [15:0]. in_rd is ignored.
  - J: op=000010, target in [25:0].
- Simultaneous events:
  - finish together with a legal handshake in LOAD: the word is accepted and written, and finish_pend←1. The session ends after that write.
  - finish together with an illegal handshake: err←1, -> DONE.
  - start outside IDLE is ignored.
- Reset mid-operation: reset_n low forces IDLE and drops imem_we immediately. A word held but not yet written is lost.

## Timing
- in_ready is a registered-state decode, with no combinational path from in_valid.
- Latency is 1 cycle from handshake edge to imem_we.
- Throughput is at most one word per 2 cycles.
- imem_addr and imem_wdata are stable for the whole imem_we cycle.
- word_count updates at the edge that ends WRITE.

## Structure
- Package mips_isa_pkg holds:
  - instr_kind_t (4-bit enum).
  - Opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_ADDI 001000, OP_J 000010.
  - Funct constants: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - The state enum.
- The main decoder and the ALU decoder import the same package.
- Sub-module instr_pack is purely combinational: kind and fields in, 32-bit word and legal flag out.
- instr_encoder contains the FSM, holding register, pointer and flags.

## Test plan
- start; ADD rs=1 rt=2 rd=3 -> imem_we at addr 0, wdata 0x00221820; word_count=1.
- LW rs=29 rt=8 imm=4, then SW rs=29 rt=8 imm=8 -> addr 0 gets 0x8FA80004, addr 1 gets 0xAFA80008.
- BEQ rs=4 rt=5 imm=0xFFFF, then J target=0x0000010 -> 0x1085FFFF, then 0x08000010.
- in_kind=4'hF with valid -> no imem_we, err=1, word_count unchanged. The next legal word is still written at the same address.
- ADDR_W=2, five requests -> four writes at addr 0-3, then full=1 and in_ready=0 with the fifth request unaccepted. finish -> done pulse.
- finish together with ADDI rs=0 rt=9 imm=7 -> 0x20090007 written, then one-cycle done, then IDLE.
- reset_n low during WRITE -> imem_we falls without waiting for clk, busy=0, all outputs at their reset values.
